// File: rtl/speech256_pkg.sv
// Shared Speech256 definitions: default widths, feeder FSM encoding and
// a few SP0256-style allophone codes used by host-side software and benches.
package speech256_pkg;
  localparam int ALLO_W_DEF = 6;
  localparam int DEPTH_DEF  = 16;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ISSUE    = 2'd1,
    ST_WAIT_LOW = 2'd2
  } feeder_state_e;

  // Pause allophones (silence of increasing length)
  localparam logic [ALLO_W_DEF-1:0] PA1 = 6'h00;
  localparam logic [ALLO_W_DEF-1:0] PA2 = 6'h01;
  localparam logic [ALLO_W_DEF-1:0] PA3 = 6'h02;
  localparam logic [ALLO_W_DEF-1:0] PA4 = 6'h03;
  localparam logic [ALLO_W_DEF-1:0] PA5 = 6'h04;
endpackage

// File: rtl/allophone_feeder_if.sv
// Host write port and speech-core handshake of the allophone feeder.
// master = host/core side, slave = feeder.
interface allophone_feeder_if
  import speech256_pkg::*;
#(
  parameter int DEPTH  = DEPTH_DEF,
  parameter int ALLO_W = ALLO_W_DEF
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [ALLO_W-1:0] wr_data;
  logic              wr_stb;
  logic              flush;
  logic              full;
  logic              empty;
  logic [CW-1:0]     count;
  logic              overflow;
  logic              ldq;
  logic [ALLO_W-1:0] data_out;
  logic              data_stb;
  logic              busy;

  modport master (
    output wr_data, wr_stb, flush, ldq,
    input  full, empty, count, overflow, data_out, data_stb, busy
  );

  modport slave (
    input  wr_data, wr_stb, flush, ldq,
    output full, empty, count, overflow, data_out, data_stb, busy
  );
endinterface

// File: rtl/allophone_fifo_mem.sv
// Allophone storage: one write port, one read port whose address is
// registered, so rdata_o follows the address presented on the previous edge.
module allophone_fifo_mem #(
  parameter int DEPTH = 16,
  parameter int W     = 6,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [W-1:0]  wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [W-1:0]  rdata_o
);
  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] raddr_q;

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    raddr_q <= raddr_i;
  end

  assign rdata_o = mem_q[raddr_q];
endmodule

// File: rtl/allophone_feeder.sv
// Circular allophone buffer between host and speech core; issues one
// data_stb per ldq high period while entries are available.
module allophone_feeder
  import speech256_pkg::*;
#(
  parameter int DEPTH  = DEPTH_DEF,
  parameter int ALLO_W = ALLO_W_DEF
) (
  input  logic               clk,
  input  logic               rst_an,
  allophone_feeder_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  feeder_state_e     state_q, state_d;
  logic [AW-1:0]     wptr_q, wptr_d, rptr_q, rptr_d, raddr;
  logic [CW-1:0]     count_q, count_d;
  logic              ovf_q, ovf_d;
  logic [ALLO_W-1:0] dout_q, dout_d, rd_data;
  logic              full, empty, pop, wr_acc;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);

  // A pop frees a slot at the same edge, so a full buffer still takes the write
  assign pop    = (state_q == ST_IDLE) && !empty && bus.ldq && !bus.flush;
  assign wr_acc = bus.wr_stb && !bus.flush && (!full || pop);

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    dout_d  = dout_q;
    if (bus.flush) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
      ovf_d   = 1'b0;
    end else begin
      if (wr_acc) wptr_d = wptr_q + 1'b1;
      if (pop) begin
        rptr_d = rptr_q + 1'b1;
        dout_d = rd_data;
      end
      count_d = count_q + CW'(wr_acc) - CW'(pop);
      if (bus.wr_stb && full && !pop) ovf_d = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:     if (pop) state_d = ST_ISSUE;
      ST_ISSUE:    state_d = ST_WAIT_LOW;
      ST_WAIT_LOW: if (!bus.ldq) state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_an) begin
      state_q <= ST_IDLE;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      dout_q  <= dout_d;
    end
  end

  // Read address tracks the next head so rd_data is the head entry each cycle
  assign raddr = rst_an ? rptr_d : '0;

  allophone_fifo_mem #(.DEPTH(DEPTH), .W(ALLO_W)) u_mem (
    .clk     (clk),
    .we_i    (wr_acc),
    .waddr_i (wptr_q),
    .wdata_i (bus.wr_data),
    .raddr_i (raddr),
    .rdata_o (rd_data)
  );

  assign bus.full     = full;
  assign bus.empty    = empty;
  assign bus.count    = count_q;
  assign bus.overflow = ovf_q;
  assign bus.data_out = dout_q;
  assign bus.data_stb = (state_q == ST_ISSUE);
  assign bus.busy     = !empty || (state_q != ST_IDLE);
endmodule

// File: tb/tb_allophone_feeder.sv
// Directed scenarios plus randomized traffic against a queue-based model
// of the allophone feeder.
module tb_allophone_feeder;
  import speech256_pkg::*;
  localparam int DEPTH  = 16;
  localparam int ALLO_W = 6;

  logic clk = 1'b0;
  logic rst_an = 1'b0;
  always #5 clk = ~clk;

  allophone_feeder_if #(.DEPTH(DEPTH), .ALLO_W(ALLO_W)) bus ();
  allophone_feeder #(.DEPTH(DEPTH), .ALLO_W(ALLO_W)) dut (
    .clk    (clk),
    .rst_an (rst_an),
    .bus    (bus)
  );

  int checks = 0;
  int failures = 0;
  string phase = "init";

  // Reference model: queue of pending codes, sticky overflow, last issued code,
  // and strobe phase (0 ready, 1 strobing, 2 waiting for ldq to drop).
  logic [ALLO_W-1:0] mq[$];
  logic              m_ovf = 1'b0;
  logic [ALLO_W-1:0] m_dout = '0;
  int                m_ph = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input logic wr, input logic [ALLO_W-1:0] d,
                            input logic fl, input logic l, input logic r);
    logic pop;
    if (!r) begin
      mq.delete();
      m_ovf = 1'b0; m_dout = '0; m_ph = 0;
      return;
    end
    pop = (m_ph == 0) && (mq.size() > 0) && l && !fl;
    if (m_ph == 1) m_ph = 2;
    else if (m_ph == 2 && !l) m_ph = 0;
    else if (pop) m_ph = 1;
    if (fl) begin
      mq.delete();
      m_ovf = 1'b0;
    end else begin
      if (pop) m_dout = mq.pop_front();
      if (wr) begin
        if (mq.size() < DEPTH) mq.push_back(d);
        else m_ovf = 1'b1;
      end
    end
  endtask

  task automatic check_all();
    chk({phase, "_count"}, bus.count, mq.size());
    chk({phase, "_empty"}, bus.empty, mq.size() == 0);
    chk({phase, "_full"}, bus.full, mq.size() == DEPTH);
    chk({phase, "_ovf"}, bus.overflow, m_ovf);
    chk({phase, "_stb"}, bus.data_stb, m_ph == 1);
    chk({phase, "_dout"}, bus.data_out, m_dout);
    chk({phase, "_busy"}, bus.busy, (mq.size() != 0) || (m_ph != 0));
  endtask

  task automatic step(input logic wr, input logic [ALLO_W-1:0] d,
                      input logic fl, input logic l, input logic r);
    bus.wr_stb = wr; bus.wr_data = d; bus.flush = fl; bus.ldq = l; rst_an = r;
    @(posedge clk);
    model_edge(wr, d, fl, l, r);
    #1;
    check_all();
  endtask

  int stbs;
  logic lq;

  initial begin
    bus.wr_stb = 0; bus.wr_data = '0; bus.flush = 0; bus.ldq = 0;

    phase = "reset";
    step(1'b1, 6'h11, 1'b0, 1'b1, 1'b0);
    step(1'b0, 6'h00, 1'b0, 1'b0, 1'b0);
    chk("reset_empty", bus.empty, 1);
    chk("reset_full", bus.full, 0);
    chk("reset_count", bus.count, 0);
    chk("reset_dout", bus.data_out, 0);
    chk("reset_stb", bus.data_stb, 0);

    phase = "single";
    step(1'b1, 6'h2A, 1'b0, 1'b1, 1'b1);
    chk("single_wr_empty", bus.empty, 0);
    chk("single_wr_stb", bus.data_stb, 0);
    step(1'b0, 6'h00, 1'b0, 1'b1, 1'b1);
    chk("single_stb", bus.data_stb, 1);
    chk("single_dout", bus.data_out, 6'h2A);
    chk("single_empty", bus.empty, 1);
    step(1'b0, 6'h00, 1'b0, 1'b1, 1'b1);
    chk("single_stb_once", bus.data_stb, 0);
    step(1'b0, 6'h00, 1'b0, 1'b0, 1'b1);

    phase = "fill";
    for (int i = 0; i < 16; i++) step(1'b1, 6'(i), 1'b0, 1'b0, 1'b1);
    step(1'b1, 6'h3F, 1'b0, 1'b0, 1'b1);
    chk("fill_full", bus.full, 1);
    chk("fill_count", bus.count, 16);
    chk("fill_ovf", bus.overflow, 1);
    phase = "drain";
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 6'h00, 1'b0, 1'b1, 1'b1);
      chk("drain_stb", bus.data_stb, 1);
      chk("drain_code", bus.data_out, i);
      step(1'b0, 6'h00, 1'b0, 1'b1, 1'b1);
      step(1'b0, 6'h00, 1'b0, 1'b0, 1'b1);
    end
    chk("drain_empty", bus.empty, 1);
    step(1'b0, 6'h00, 1'b1, 1'b0, 1'b1);
    chk("flush_clr_ovf", bus.overflow, 0);

    phase = "hold";
    for (int i = 0; i < 3; i++) step(1'b1, 6'(8'h10 + i), 1'b0, 1'b0, 1'b1);
    stbs = 0;
    for (int i = 0; i < 50; i++) begin
      step(1'b0, 6'h00, 1'b0, 1'b1, 1'b1);
      if (bus.data_stb) stbs++;
    end
    chk("hold_one_stb", stbs, 1);
    step(1'b0, 6'h00, 1'b0, 1'b0, 1'b1);
    stbs = 0;
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 6'h00, 1'b0, 1'b1, 1'b1);
      if (bus.data_stb) begin
        stbs++;
        chk("hold_second_code", bus.data_out, 6'h11);
      end
    end
    chk("hold_second_stb", stbs, 1);
    step(1'b0, 6'h00, 1'b0, 1'b0, 1'b1);
    step(1'b0, 6'h00, 1'b1, 1'b0, 1'b1);

    phase = "fullpop";
    for (int i = 0; i < 16; i++) step(1'b1, 6'(8'h20 + i), 1'b0, 1'b0, 1'b1);
    step(1'b1, 6'h3E, 1'b0, 1'b1, 1'b1);
    chk("fullpop_count", bus.count, 16);
    chk("fullpop_ovf", bus.overflow, 0);
    chk("fullpop_dout", bus.data_out, 6'h20);
    step(1'b0, 6'h00, 1'b0, 1'b0, 1'b1);
    step(1'b0, 6'h00, 1'b0, 1'b0, 1'b1);
    step(1'b0, 6'h00, 1'b1, 1'b0, 1'b1);

    phase = "flushwr";
    for (int i = 0; i < 8; i++) step(1'b1, 6'(8'h30 + i), 1'b0, 1'b0, 1'b1);
    step(1'b1, PA2, 1'b1, 1'b1, 1'b1);
    chk("flushwr_count", bus.count, 0);
    chk("flushwr_empty", bus.empty, 1);
    chk("flushwr_ovf", bus.overflow, 0);
    stbs = 0;
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 6'h00, 1'b0, 1'b1, 1'b1);
      if (bus.data_stb) stbs++;
    end
    chk("flushwr_no_stb", stbs, 0);
    step(1'b0, 6'h00, 1'b0, 1'b0, 1'b1);

    phase = "midrst";
    for (int i = 0; i < 5; i++) step(1'b1, 6'(8'h05 + i), 1'b0, 1'b0, 1'b1);
    step(1'b0, 6'h00, 1'b0, 1'b1, 1'b1);
    chk("midrst_issue", bus.data_stb, 1);
    step(1'b0, 6'h00, 1'b0, 1'b1, 1'b0);
    chk("midrst_stb", bus.data_stb, 0);
    chk("midrst_count", bus.count, 0);
    chk("midrst_dout", bus.data_out, 0);
    step(1'b0, 6'h00, 1'b0, 1'b1, 1'b1);
    chk("midrst_release_stb", bus.data_stb, 0);

    phase = "rand";
    lq = 1'b0;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 3) == 0) lq = ~lq;
      step(1'($urandom_range(0, 1)), 6'($urandom), 1'($urandom_range(0, 39) == 0),
           lq, 1'($urandom_range(0, 99) != 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
